riscv_top: RTL and testbench

- Board-level shell for the RISC-V system. It owns the external clock, reset, the UART pins and the LEDs.
- It contains an 8N1 UART transceiver, a 16-entry byte FIFO and a status/LED block.
- After reset it sends one ready byte. Every valid received byte is then echoed back on Tx.
- SIM=1 shortens the bit period so simulation runs fast.

---
 rtl/riscv_top.sv | 255 +++++++++++++++++++++++++
 tb/tb_riscv_top.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_top.sv
// Board shell: 8N1 UART echo with a 16-entry byte FIFO, a one-shot ready byte and status LEDs.
// Every received byte with a good stop bit is queued and sent back out on Tx.
module riscv_top #(
  parameter int unsigned SIM          = 0,
  parameter int unsigned SYS_CLK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter logic [7:0]  READY_BYTE   = 8'h52
) (
  input  logic       EXCLK,
  input  logic       btnC,
  input  logic       Rx,
  output logic       Tx,
  output logic [3:0] led
);

  localparam int unsigned DIV  = (SIM != 0) ? 4 : SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF = (DIV / 2 > 0) ? DIV / 2 : 1;
  localparam int unsigned CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  // ---------------- FIFO ----------------
  logic [7:0] fifo_mem [16];
  logic [3:0] fifo_wptr_q, fifo_wptr_d;
  logic [3:0] fifo_rptr_q, fifo_rptr_d;
  logic [4:0] fifo_cnt_q, fifo_cnt_d;
  logic       fifo_empty, fifo_full;
  logic       rx_push, tx_pop, push_ok;

  // ---------------- RX ----------------
  logic [1:0]  rx_sync_q;
  logic        rx_s, rx_prev_q;
  uart_state_e rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_toggle_q, rx_toggle_d;
  logic        overflow_q, overflow_d;

  // ---------------- TX ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;
  logic        tx_is_ready_q, tx_is_ready_d;
  logic        ready_req_q, ready_req_d;
  logic        ready_pending_q, ready_pending_d;
  logic        ready_sent_q, ready_sent_d;
  logic        tx_avail, tx_load;
  logic [7:0]  tx_byte;
  logic        tx_tick;

  assign rx_s       = rx_sync_q[1];
  assign fifo_empty = (fifo_cnt_q == 5'd0);
  assign fifo_full  = (fifo_cnt_q == 5'd16);
  // A full FIFO still takes a push when the same cycle pops.
  assign push_ok    = rx_push & (~fifo_full | tx_pop);

  assign fifo_wptr_d = push_ok ? fifo_wptr_q + 4'd1 : fifo_wptr_q;
  assign fifo_rptr_d = tx_pop ? fifo_rptr_q + 4'd1 : fifo_rptr_q;
  assign fifo_cnt_d  = fifo_cnt_q + {4'd0, push_ok} - {4'd0, tx_pop};
  assign overflow_d  = overflow_q | (rx_push & fifo_full & ~tx_pop);

  always_ff @(posedge EXCLK) begin
    if (push_ok) fifo_mem[fifo_wptr_q] <= rx_shift_q;
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    frame_err_d = frame_err_q;
    rx_toggle_d = rx_toggle_q;
    rx_push     = 1'b0;
    case (rx_state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = StStart;
          rx_cnt_d   = '0;
        end
      end
      StStart: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          // High at mid-start means a glitch, not a frame.
          rx_state_d = rx_s ? StIdle : StData;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      StData: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = StStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      StStop: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = StIdle;
          if (rx_s) begin
            rx_push     = 1'b1;
            rx_toggle_d = ~rx_toggle_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  assign tx_tick  = (tx_cnt_q == DIV_LAST);
  assign tx_avail = ready_pending_q | ~fifo_empty;
  assign tx_byte  = ready_pending_q ? READY_BYTE : fifo_mem[fifo_rptr_q];

  always_comb begin
    tx_state_d      = tx_state_q;
    tx_cnt_d        = tx_cnt_q;
    tx_bit_d        = tx_bit_q;
    tx_shift_d      = tx_shift_q;
    tx_d            = tx_q;
    tx_is_ready_d   = tx_is_ready_q;
    ready_req_d     = ready_req_q;
    ready_pending_d = ready_pending_q;
    ready_sent_d    = ready_sent_q;
    tx_load         = 1'b0;
    tx_pop          = 1'b0;

    // First cycle out of reset requests the ready byte exactly once.
    if (!ready_req_q) begin
      ready_req_d     = 1'b1;
      ready_pending_d = 1'b1;
    end

    case (tx_state_q)
      StIdle: begin
        tx_d    = 1'b1;
        tx_load = tx_avail;
      end
      StStart: begin
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = StData;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      StData: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = StStop;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      StStop: begin
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_state_d = StIdle;
          if (tx_is_ready_q) ready_sent_d = 1'b1;
          // Chain straight into the next start bit for back-to-back frames.
          tx_load = tx_avail;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = StIdle;
    endcase

    if (tx_load) begin
      tx_state_d    = StStart;
      tx_cnt_d      = '0;
      tx_d          = 1'b0;
      tx_shift_d    = tx_byte;
      tx_is_ready_d = ready_pending_q;
      if (ready_pending_q) ready_pending_d = 1'b0;
      else                 tx_pop          = 1'b1;
    end
  end

  always_ff @(posedge EXCLK) begin
    if (!btnC) begin
      fifo_wptr_q     <= 4'd0;
      fifo_rptr_q     <= 4'd0;
      fifo_cnt_q      <= 5'd0;
      rx_sync_q       <= 2'b11;
      rx_prev_q       <= 1'b1;
      rx_state_q      <= StIdle;
      rx_cnt_q        <= '0;
      rx_bit_q        <= 3'd0;
      rx_shift_q      <= 8'd0;
      frame_err_q     <= 1'b0;
      rx_toggle_q     <= 1'b0;
      overflow_q      <= 1'b0;
      tx_state_q      <= StIdle;
      tx_cnt_q        <= '0;
      tx_bit_q        <= 3'd0;
      tx_shift_q      <= 8'd0;
      tx_q            <= 1'b1;
      tx_is_ready_q   <= 1'b0;
      ready_req_q     <= 1'b0;
      ready_pending_q <= 1'b0;
      ready_sent_q    <= 1'b0;
    end else begin
      fifo_wptr_q     <= fifo_wptr_d;
      fifo_rptr_q     <= fifo_rptr_d;
      fifo_cnt_q      <= fifo_cnt_d;
      rx_sync_q       <= {rx_sync_q[0], Rx};
      rx_prev_q       <= rx_s;
      rx_state_q      <= rx_state_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_bit_q        <= rx_bit_d;
      rx_shift_q      <= rx_shift_d;
      frame_err_q     <= frame_err_d;
      rx_toggle_q     <= rx_toggle_d;
      overflow_q      <= overflow_d;
      tx_state_q      <= tx_state_d;
      tx_cnt_q        <= tx_cnt_d;
      tx_bit_q        <= tx_bit_d;
      tx_shift_q      <= tx_shift_d;
      tx_q            <= tx_d;
      tx_is_ready_q   <= tx_is_ready_d;
      ready_req_q     <= ready_req_d;
      ready_pending_q <= ready_pending_d;
      ready_sent_q    <= ready_sent_d;
    end
  end

  assign Tx  = tx_q;
  assign led = {rx_toggle_q, overflow_q, frame_err_q, ready_sent_q};

endmodule

// File: tb/tb_riscv_top.sv
// Directed bench for riscv_top at SIM=1 (4 clocks/bit): ready byte, echo, framing error,
// glitch rejection, streaming, FIFO overflow and mid-frame reset.
module tb_riscv_top;

  logic       clk  = 1'b0;
  logic       btnC = 1'b0;
  logic       Rx   = 1'b1;
  logic       Tx;
  logic [3:0] led;
  int         cyc  = 0;
  int         checks = 0;
  int         errors = 0;

  riscv_top #(.SIM(1)) dut (
    .EXCLK(clk),
    .btnC (btnC),
    .Rx   (Rx),
    .Tx   (Tx),
    .led  (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic       stop;
  } frame_t;
  frame_t mon_q[$];

  // Tx line decoder: start cycle recorded at first low sample, bits sampled mid-bit.
  initial begin
    logic [7:0] b;
    int         st;
    forever begin
      @(negedge clk);
      if (Tx === 1'b0) begin
        st = cyc;
        repeat (6) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          b[j] = Tx;
          if (j < 7) repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        mon_q.push_back('{data: b, start: st, stop: Tx});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, required end before it",
             cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  // Called just after a rising edge; leaves Rx at the stop value after 40 cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int c0);
    c0 = cyc;
    Rx = 1'b0;
    repeat (4) step();
    for (int j = 0; j < 8; j++) begin
      Rx = d[j];
      repeat (4) step();
    end
    Rx = stop;
    repeat (4) step();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       echo;
    logic [3:0] led;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_b[18];
  int         c0s[18];
  int         c0, c_rel, limit;

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, echo: 1'b1, led: 4'b1001};
    vecs[1] = '{data: 8'h00, stop: 1'b0, echo: 1'b0, led: 4'b1011};
    vecs[2] = '{data: 8'h33, stop: 1'b1, echo: 1'b1, led: 4'b0011};
    vecs[3] = '{data: 8'hC3, stop: 1'b1, echo: 1'b1, led: 4'b1011};
    vecs[4] = '{data: 8'hFF, stop: 1'b0, echo: 1'b0, led: 4'b1011};
    vecs[5] = '{data: 8'h80, stop: 1'b1, echo: 1'b1, led: 4'b0011};

    // Reset and ready byte
    repeat (4) step();
    @(negedge clk);
    check("reset_tx", Tx, 1'b1);
    check("reset_led", led, 4'b0000);
    step();
    btnC  = 1'b1;
    c_rel = cyc;
    wait_until(c_rel + 1);
    check("ready_tx_still_idle", Tx, 1'b1);
    wait_until(c_rel + 2);
    check("ready_start_low", Tx, 1'b0);
    wait_until(c_rel + 41);
    check("ready_led_before_stop_end", led, 4'b0000);
    wait_until(c_rel + 42);
    check("ready_led_after_stop_end", led, 4'b0001);
    wait_until(c_rel + 45);
    check("ready_frame_count", mon_q.size(), 1);
    if (mon_q.size() == 1) begin
      check("ready_byte", mon_q[0].data, 8'h52);
      check("ready_start_cycle", mon_q[0].start, c_rel + 2);
      check("ready_stop_bit", mon_q[0].stop, 1'b1);
    end

    // Table: echo, framing error, led[3] toggling
    for (int i = 0; i < 6; i++) begin
      step();
      mon_q.delete();
      send_frame(vecs[i].data, vecs[i].stop, c0);
      Rx = 1'b1;
      wait_until(c0 + 82);
      check($sformatf("vec%0d_echo_count", i), mon_q.size(), {31'd0, vecs[i].echo});
      if (vecs[i].echo && mon_q.size() == 1) begin
        check($sformatf("vec%0d_echo_byte", i), mon_q[0].data, vecs[i].data);
        check($sformatf("vec%0d_echo_start", i), mon_q[0].start, c0 + 42);
      end
      check($sformatf("vec%0d_led", i), led, vecs[i].led);
    end

    // One-cycle glitch on Rx
    step();
    mon_q.delete();
    Rx = 1'b0;
    step();
    Rx = 1'b1;
    c0 = cyc;
    wait_until(c0 + 60);
    check("glitch_no_echo", mon_q.size(), 0);
    check("glitch_led", led, 4'b0011);

    // 18 back-to-back bytes while TX drains
    step();
    mon_q.delete();
    for (int i = 0; i < 18; i++) begin
      exp_b[i] = 8'h3C + 8'(i * 17);
      send_frame(exp_b[i], 1'b1, c0s[i]);
    end
    Rx = 1'b1;
    limit = c0s[17] + 100;
    while (mon_q.size() < 18 && cyc < limit) @(negedge clk);
    check("stream_count", mon_q.size(), 18);
    for (int i = 0; i < 18; i++) begin
      if (i < mon_q.size()) begin
        check($sformatf("stream%0d_byte", i), mon_q[i].data, exp_b[i]);
        check($sformatf("stream%0d_start", i), mon_q[i].start, c0s[i] + 42);
      end
    end
    check("stream_led", led, 4'b0011);

    // Overflow: hold TX in the ready byte's stop bit while 17 bytes arrive
    step();
    btnC = 1'b0;
    repeat (3) step();
    check("reset2_tx", Tx, 1'b1);
    check("reset2_led", led, 4'b0000);
    btnC  = 1'b1;
    c_rel = cyc;
    wait_until(c_rel + 40);
    force dut.tx_tick = 1'b0;
    mon_q.delete();
    step();
    for (int i = 0; i < 17; i++) begin
      exp_b[i] = 8'hC0 ^ 8'(i * 5);
      send_frame(exp_b[i], 1'b1, c0s[i]);
    end
    Rx = 1'b1;
    check("fill_led_16_pushed", led, 4'b0000);
    step();
    step();
    check("overflow_led", led, 4'b1100);
    check("held_no_echo", mon_q.size(), 0);
    release dut.tx_tick;
    limit = cyc + 720;
    while (mon_q.size() < 16 && cyc < limit) @(negedge clk);
    check("overflow_echo_count", mon_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < mon_q.size()) check($sformatf("overflow%0d_byte", i), mon_q[i].data, exp_b[i]);
    end
    repeat (60) @(negedge clk);
    check("overflow_17th_lost", mon_q.size(), 16);
    check("overflow_led_final", led, 4'b1101);

    // Reset during an echo frame
    step();
    mon_q.delete();
    send_frame(8'h5A, 1'b1, c0);
    Rx = 1'b1;
    wait_until(c0 + 45);
    check("midframe_start_bit", Tx, 1'b0);
    check("midframe_led", led, 4'b0101);
    btnC = 1'b0;
    wait_until(c0 + 46);
    check("midframe_reset_tx", Tx, 1'b1);
    check("midframe_reset_led", led, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
